// File: rtl/id_ex_ctrl_pipe.sv
// ID-stage decode and ID/EX control register: decodes the IF/ID instruction into the EX control bundle,
// interlocks load-use hazards for LOAD_USE_CYCLES bubbles, honours flush/hold, and traps unsupported opcodes.
module id_ex_ctrl_pipe #(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter bit          TRAP_ILLEGAL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic        ex_pc_plus8,
    output logic        ex_reg_dest,
    output logic        ex_alu_reg_sel,
    output logic        ex_jal_ctrl,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic [3:0]  ex_alu_ctrl,
    output logic [2:0]  ex_alu_src_b,
    output logic [2:0]  ex_ldst_ctrl,
    output logic [3:0]  ex_jump_branch,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_wreg,
    output logic        ex_illegal,
    output logic        illegal_seen
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,  ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6,  ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

    localparam logic [2:0] SRC_RT = 3'b000, SRC_RS = 3'b001, SRC_SEXT = 3'b010;
    localparam logic [2:0] SRC_ZEXT = 3'b011, SRC_ZERO = 3'b100, SRC_SHAMT = 3'b101;

    localparam logic [3:0] JB_JUMP = 4'b0001, JB_JR   = 4'b0010, JB_BEQ  = 4'b0011, JB_BNE  = 4'b0100;
    localparam logic [3:0] JB_BLEZ = 4'b0101, JB_BGTZ = 4'b0110, JB_BLTZ = 4'b0111, JB_BGEZ = 4'b1000;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    typedef struct packed {
        logic       pc_plus8;
        logic       reg_dest;
        logic       alu_reg_sel;   // 1: ALU operand A is rt (shifts), 0: rs
        logic       jal_ctrl;
        logic       reg_write;
        logic       mem_to_reg;
        logic [3:0] alu_ctrl;
        logic [2:0] alu_src_b;
        logic [2:0] ldst_ctrl;
        logic [3:0] jump_branch;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wreg;
    } ctrl_t;

    // ALUdec: ALU operation from opcode/funct
    function automatic logic [3:0] alu_dec(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] res;
        res = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_SLL, F_SLLV: res = ALU_SLL;
                    F_SRL, F_SRLV: res = ALU_SRL;
                    F_SRA, F_SRAV: res = ALU_SRA;
                    F_SUBU:        res = ALU_SUB;
                    F_AND:         res = ALU_AND;
                    F_OR:          res = ALU_OR;
                    F_XOR:         res = ALU_XOR;
                    F_NOR:         res = ALU_NOR;
                    F_SLT:         res = ALU_SLT;
                    F_SLTU:        res = ALU_SLTU;
                    default:       res = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: res = ALU_SUB;
            OP_SLTI:  res = ALU_SLT;
            OP_SLTIU: res = ALU_SLTU;
            OP_ANDI:  res = ALU_AND;
            OP_ORI:   res = ALU_OR;
            OP_XORI:  res = ALU_XOR;
            OP_LUI:   res = ALU_LUI;
            default:  res = ALU_ADD;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] ldst_code(input logic [5:0] op);
        logic [2:0] res;
        case (op)
            OP_LB:   res = 3'b000;
            OP_LH:   res = 3'b001;
            OP_LW:   res = 3'b010;
            OP_LBU:  res = 3'b011;
            OP_LHU:  res = 3'b100;
            OP_SB:   res = 3'b101;
            OP_SH:   res = 3'b110;
            OP_SW:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    logic [5:0] opcode_s, funct_s;
    logic [4:0] rd_s;
    logic       unused_shamt_s;
    ctrl_t      raw_s, dec_s;
    logic       legal_s, uses_rs_s, uses_rt_s, hazard_s;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t      ex_q, ex_d;
    logic       ex_valid_q, ex_valid_d;
    logic       ex_illegal_q, ex_illegal_d;
    logic       illegal_seen_q, illegal_seen_d;

    assign opcode_s       = id_instr[31:26];
    assign funct_s        = id_instr[5:0];
    assign rd_s           = id_instr[15:11];
    assign unused_shamt_s = ^id_instr[10:6];

    // Instruction decode into the raw control bundle plus legality and source-usage flags
    always_comb begin
        raw_s           = '0;
        legal_s         = 1'b0;
        uses_rs_s       = 1'b0;
        uses_rt_s       = 1'b0;
        raw_s.rs        = id_instr[25:21];
        raw_s.rt        = id_instr[20:16];
        raw_s.alu_ctrl  = alu_dec(opcode_s, funct_s);
        raw_s.ldst_ctrl = ldst_code(opcode_s);
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    F_SLL, F_SRL, F_SRA: begin
                        legal_s = 1'b1; uses_rt_s = 1'b1;
                        raw_s.reg_dest = 1'b1; raw_s.reg_write = 1'b1;
                        raw_s.alu_reg_sel = 1'b1; raw_s.alu_src_b = SRC_SHAMT;
                    end
                    F_SLLV, F_SRLV, F_SRAV: begin
                        legal_s = 1'b1; uses_rs_s = 1'b1; uses_rt_s = 1'b1;
                        raw_s.reg_dest = 1'b1; raw_s.reg_write = 1'b1;
                        raw_s.alu_reg_sel = 1'b1; raw_s.alu_src_b = SRC_RS;
                    end
                    F_JR: begin
                        legal_s = 1'b1; uses_rs_s = 1'b1; raw_s.jump_branch = JB_JR;
                    end
                    F_JALR: begin
                        legal_s = 1'b1; uses_rs_s = 1'b1; raw_s.jump_branch = JB_JR;
                        raw_s.reg_dest = 1'b1; raw_s.reg_write = 1'b1; raw_s.pc_plus8 = 1'b1;
                    end
                    F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        legal_s = 1'b1; uses_rs_s = 1'b1; uses_rt_s = 1'b1;
                        raw_s.reg_dest = 1'b1; raw_s.reg_write = 1'b1; raw_s.alu_src_b = SRC_RT;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                legal_s = 1'b1; uses_rs_s = 1'b1;
                raw_s.reg_write = 1'b1; raw_s.mem_to_reg = 1'b1; raw_s.alu_src_b = SRC_SEXT;
            end
            OP_SB, OP_SH, OP_SW: begin
                legal_s = 1'b1; uses_rs_s = 1'b1; uses_rt_s = 1'b1; raw_s.alu_src_b = SRC_SEXT;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                legal_s = 1'b1; uses_rs_s = 1'b1; raw_s.reg_write = 1'b1; raw_s.alu_src_b = SRC_SEXT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                legal_s = 1'b1; uses_rs_s = 1'b1; raw_s.reg_write = 1'b1; raw_s.alu_src_b = SRC_ZEXT;
            end
            OP_LUI: begin
                legal_s = 1'b1; raw_s.reg_write = 1'b1; raw_s.alu_src_b = SRC_ZEXT;
            end
            OP_J: begin
                legal_s = 1'b1; raw_s.jump_branch = JB_JUMP;
            end
            OP_JAL: begin
                legal_s = 1'b1; raw_s.jump_branch = JB_JUMP; raw_s.jal_ctrl = 1'b1;
                raw_s.pc_plus8 = 1'b1; raw_s.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                legal_s = 1'b1; uses_rs_s = 1'b1; uses_rt_s = 1'b1; raw_s.alu_src_b = SRC_RT;
                raw_s.jump_branch = (opcode_s == OP_BEQ) ? JB_BEQ : JB_BNE;
            end
            OP_BLEZ, OP_BGTZ: begin
                legal_s = 1'b1; uses_rs_s = 1'b1; raw_s.alu_src_b = SRC_ZERO;
                raw_s.jump_branch = (opcode_s == OP_BLEZ) ? JB_BLEZ : JB_BGTZ;
            end
            OP_REGIMM: begin
                legal_s = 1'b1; uses_rs_s = 1'b1; raw_s.alu_src_b = SRC_ZERO;
                raw_s.jump_branch = (id_instr[20:16] == 5'd0) ? JB_BLTZ : JB_BGEZ;
            end
            default: legal_s = 1'b0;
        endcase
        raw_s.wreg = raw_s.jal_ctrl ? 5'd31 : (raw_s.reg_dest ? rd_s : id_instr[20:16]);
    end

    // Unsupported instructions decode to an all-zero bundle (a valid NOP when not trapped)
    assign dec_s = legal_s ? raw_s : '0;

    assign hazard_s = id_valid & ex_valid_q & ex_q.mem_to_reg & (ex_q.wreg != 5'd0) &
                      ((legal_s & uses_rs_s & (id_instr[25:21] == ex_q.wreg)) |
                       (legal_s & uses_rt_s & (id_instr[20:16] == ex_q.wreg)));

    // Per-cycle priority: flush, hold, interlock countdown, hazard, then normal issue
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ex_d           = ex_q;
        ex_valid_d     = ex_valid_q;
        ex_illegal_d   = 1'b0;
        illegal_seen_d = illegal_seen_q;
        id_stall       = 1'b0;
        if (rst) begin
            id_stall = 1'b0;
        end else if (flush) begin
            ex_d = '0; ex_valid_d = 1'b0; state_d = ST_RUN; cnt_d = 3'd0;
        end else if (ex_hold) begin
            id_stall = 1'b1;
        end else if (state_q == ST_STALL) begin
            ex_d = '0; ex_valid_d = 1'b0; id_stall = 1'b1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_STALL;
            end
        end else if (hazard_s) begin
            ex_d = '0; ex_valid_d = 1'b0; id_stall = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                state_d = ST_STALL;
                cnt_d   = 3'(LOAD_USE_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
            end
        end else if (!id_valid) begin
            ex_d = '0; ex_valid_d = 1'b0;
        end else if (!legal_s && TRAP_ILLEGAL) begin
            ex_d = '0; ex_valid_d = 1'b0; ex_illegal_d = 1'b1; illegal_seen_d = 1'b1;
        end else begin
            ex_d = dec_s; ex_valid_d = 1'b1;
        end
    end

    // ID/EX register and interlock state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            cnt_q          <= 3'd0;
            ex_q           <= '0;
            ex_valid_q     <= 1'b0;
            ex_illegal_q   <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ex_q           <= ex_d;
            ex_valid_q     <= ex_valid_d;
            ex_illegal_q   <= ex_illegal_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc_plus8    = ex_q.pc_plus8;
    assign ex_reg_dest    = ex_q.reg_dest;
    assign ex_alu_reg_sel = ex_q.alu_reg_sel;
    assign ex_jal_ctrl    = ex_q.jal_ctrl;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_to_reg  = ex_q.mem_to_reg;
    assign ex_alu_ctrl    = ex_q.alu_ctrl;
    assign ex_alu_src_b   = ex_q.alu_src_b;
    assign ex_ldst_ctrl   = ex_q.ldst_ctrl;
    assign ex_jump_branch = ex_q.jump_branch;
    assign ex_rs          = ex_q.rs;
    assign ex_rt          = ex_q.rt;
    assign ex_wreg        = ex_q.wreg;
    assign ex_illegal     = ex_illegal_q;
    assign illegal_seen   = illegal_seen_q;

endmodule
